mux_rr_nxw: RTL and testbench
=============================

MUX_RR_NXW -- requirements
Module: mux_rr_nxw

Interface
REQ-001 SHALL have parameter W, default 8: data width per channel in bits.
REQ-002 SHALL have parameter N, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL have localparam SELW = clog2(N), not overridable.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port Mode, input, 1 bit: 0 = fixed select by Sel, 1 = round-robin arbitration.
REQ-007 SHALL have port Sel, input, SELW bits: channel index, used only when Mode = 0.
REQ-008 SHALL have port In_Data, input, N*W bits: channel k occupies bits [k*W +: W].
REQ-009 SHALL have port In_Valid, input, N bits: per-channel valid.
REQ-010 SHALL have port In_Ready, output, N bits: per-channel ready.
REQ-011 SHALL have port S, output, W bits: registered selected data.
REQ-012 SHALL have port Out_Chan, output, SELW bits: index of the channel that supplied S.
REQ-013 SHALL have port Out_Valid, output, 1 bit: S and Out_Chan valid.
REQ-014 SHALL have port Out_Ready, input, 1 bit: downstream accepts.

Function
REQ-015 SHALL contain a one-entry output register {S, Out_Chan}, with Out_Valid as its full flag.
REQ-016 SHALL define can_accept = !Out_Valid | Out_Ready; a drain and a load in the same cycle are both legal.
REQ-017 SHALL, in Mode 0, assert In_Ready[Sel] = can_accept and hold every other In_Ready bit at 0.
REQ-018 SHALL, in Mode 0 with Sel >= N, hold all In_Ready bits at 0 and load nothing.
REQ-019 SHALL, in Mode 1, grant the first channel with In_Valid set, searching from rr_ptr upward with wrap N-1 -> 0, and assert only that channel's In_Ready = can_accept.
REQ-020 SHALL count a transfer on channel k in the cycle In_Valid[k] & In_Ready[k]; at that edge, S <= In_Data[k], Out_Chan <= k, Out_Valid <= 1.
REQ-021 SHALL keep latency at exactly 1 cycle from the accepting edge to Out_Valid high.
REQ-022 SHALL, when rr_ptr advances, set it to (granted k + 1) mod N, only on an accepted transfer in Mode 1; rr_ptr is otherwise unchanged, including through all Mode 0 operation.
REQ-023 SHALL clear Out_Valid on Out_Valid & Out_Ready with no new transfer in the same cycle; S and Out_Chan then hold their last values.
REQ-024 SHALL hold S and Out_Chan stable while Out_Valid & !Out_Ready.
REQ-025 SHALL apply Mode or Sel changes from the next arbitration only; held output data is unaffected.
REQ-026 SHALL keep In_Ready combinational from Mode, Sel, In_Valid, rr_ptr, Out_Valid and Out_Ready; it SHALL NOT depend on In_Data.
REQ-027 SHALL sustain full throughput of 1 transfer per cycle while Out_Ready stays high.

Reset
REQ-028 SHALL, while Rst_n = 0, asynchronously force Out_Valid = 0, S = 0, Out_Chan = 0 and rr_ptr = 0; In_Ready then follows REQ-017/019 with can_accept = 1.
REQ-029 SHALL drop any held data when reset asserts mid-operation; no transfer completes on the edge where Rst_n deasserts.

Structure
REQ-030 SHALL place the mode encodings MODE_FIXED = 0 and MODE_RR = 1 in the team's shared constants package/include.
REQ-031 SHALL implement round-robin grant plus pointer in one sub-module, rr_arb_n (parameter N; inputs req, advance; outputs grant index, grant_valid).
REQ-032 SHALL implement the data mux as a W-bit N:1 indexed select, with no per-bit instances.

Verification (W=8, N=4)
REQ-033 SHALL cover reset: Rst_n low mid-transfer with Out_Valid = 1 -> Out_Valid, S, Out_Chan = 0 immediately, with no clock edge needed.
REQ-034 SHALL cover fixed mode: Mode=0, Sel=2, In_Valid=4'b1111, In_Data ch2=8'hA5, Out_Ready=1 -> In_Ready=4'b0100; next cycle S=8'hA5, Out_Chan=2, Out_Valid=1.
REQ-035 SHALL cover round-robin order: Mode=1, all channels valid, Out_Ready=1 for 8 cycles -> Out_Chan sequence 0,1,2,3,0,1,2,3.
REQ-036 SHALL cover round-robin skip: Mode=1, rr_ptr=1, In_Valid=4'b1001 -> grant ch3, then rr_ptr=0 and the next grant is ch0.
REQ-037 SHALL cover backpressure: Out_Valid=1, S=8'h3C, Out_Ready=0 for 3 cycles with inputs valid -> In_Ready=0 and S stays 8'h3C; on Out_Ready=1, a new word loads on the same edge.
REQ-038 SHALL cover the mode switch: Mode 1 -> 0 with Sel=1 while holding -> held S unchanged; rr_ptr frozen; after returning to Mode 1, arbitration resumes from the frozen rr_ptr.

Source files
------------

// File: rtl/mux_rr_nxw_pkg.sv
// Shared constants for the N-channel W-bit output-registered mux.
package mux_rr_nxw_pkg;

    // Channel selection modes driven on the Mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : mux_rr_nxw_pkg

// File: rtl/mux_rr_nxw_rr_arb_n.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping N-1 -> 0. The pointer only moves when the caller reports an
// accepted grant via advance.
module rr_arb_n #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;

    // Priority search from ptr_q upward; scanning the offsets in reverse lets
    // the smallest offset win without an early exit.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'(idx);
            end
        end
    end

    // Next pointer is one past the channel that actually transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = SELW'((int'(grant_idx) + 1) % N);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb_n

// File: rtl/mux_rr_nxw.sv
// N:1 mux with a one-entry registered output stage. Mode 0 passes the channel
// chosen by Sel; Mode 1 arbitrates round-robin. A drain and a load may share a
// cycle, so a continuously ready sink sees one word per cycle.
module mux_rr_nxw
    import mux_rr_nxw_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Mode,
    input  logic [SELW-1:0] Sel,
    input  logic [N*W-1:0]  In_Data,
    input  logic [N-1:0]    In_Valid,
    output logic [N-1:0]    In_Ready,
    output logic [W-1:0]    S,
    output logic [SELW-1:0] Out_Chan,
    output logic            Out_Valid,
    input  logic            Out_Ready
);

    logic [W-1:0]    chan_data [N];
    logic [SELW-1:0] grant_idx;
    logic            grant_valid;
    logic            advance;
    logic            can_accept;
    logic            xfer;
    logic [SELW-1:0] xfer_idx;

    logic [W-1:0]    s_q, s_d;
    logic [SELW-1:0] chan_q, chan_d;
    logic            valid_q, valid_d;

    // Unpack the flat data bus into one word per channel.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign chan_data[gi] = In_Data[gi*W +: W];
        end
    endgenerate

    rr_arb_n #(.N(N)) u_arb (
        .clk         (Clk),
        .rst_n       (Rst_n),
        .req         (In_Valid),
        .advance     (advance),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Ready/transfer decode; deliberately independent of In_Data.
    always_comb begin
        can_accept = !valid_q || Out_Ready;
        In_Ready   = '0;
        xfer       = 1'b0;
        xfer_idx   = '0;
        if (Mode == MODE_RR) begin
            if (grant_valid) begin
                In_Ready[grant_idx] = can_accept;
                xfer_idx            = grant_idx;
                xfer                = can_accept;
            end
        end else if (int'(Sel) < N) begin
            // An out-of-range Sel selects nothing and loads nothing.
            In_Ready[Sel] = can_accept;
            xfer_idx      = Sel;
            xfer          = can_accept && In_Valid[Sel];
        end
        advance = (Mode == MODE_RR) && xfer;
    end

    // Output register next state: load wins over drain; data holds on drain.
    always_comb begin
        s_d     = s_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (xfer) begin
            s_d     = chan_data[xfer_idx];
            chan_d  = xfer_idx;
            valid_d = 1'b1;
        end else if (Out_Ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s_q     <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign S         = s_q;
    assign Out_Chan  = chan_q;
    assign Out_Valid = valid_q;

endmodule : mux_rr_nxw

// File: tb/tb_mux_rr_nxw.sv
// Directed bench for mux_rr_nxw (W=8, N=4): a per-cycle vector table plus
// hand-written reset sequences.
module tb_mux_rr_nxw;

    localparam int W = 8;
    localparam int N = 4;
    localparam logic [31:0] DATA0 = 32'h44A5_2211; // ch3=44 ch2=A5 ch1=22 ch0=11
    localparam logic [31:0] DATA1 = 32'h443C_2211; // ch2 carries 3C

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Mode;
    logic [1:0]   Sel;
    logic [31:0]  In_Data;
    logic [3:0]   In_Valid;
    logic [3:0]   In_Ready;
    logic [7:0]   S;
    logic [1:0]   Out_Chan;
    logic         Out_Valid;
    logic         Out_Ready;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_s;
        logic [1:0]  exp_chan;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [27];

    always #5 Clk = ~Clk;

    mux_rr_nxw #(.W(W), .N(N)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Mode      (Mode),
        .Sel       (Sel),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .S         (S),
        .Out_Chan  (Out_Chan),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic m, input logic [1:0] sl, input logic [3:0] v,
                                 input logic [31:0] d, input logic r, input logic [3:0] er,
                                 input logic [7:0] es, input logic [1:0] ec, input logic ev);
        vec_t t;
        t.mode = m; t.sel = sl; t.valid = v; t.data = d; t.ordy = r;
        t.exp_ready = er; t.exp_s = es; t.exp_chan = ec; t.exp_valid = ev;
        return t;
    endfunction

    initial begin
        // mode sel valid data ordy | In_Ready | S chan valid after the edge
        vecs[0]  = mkv(0, 2, 4'hF, DATA0, 1, 4'b0100, 8'hA5, 2, 1); // fixed select ch2
        vecs[1]  = mkv(0, 1, 4'h0, DATA0, 1, 4'b0010, 8'hA5, 2, 0); // drain, no load
        vecs[2]  = mkv(0, 0, 4'h1, DATA0, 0, 4'b0001, 8'h11, 0, 1); // empty reg accepts
        vecs[3]  = mkv(0, 3, 4'h8, DATA0, 0, 4'b0000, 8'h11, 0, 1); // full, stalled
        vecs[4]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b0001, 8'h11, 0, 1); // rr order 0..3,0..3
        vecs[5]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b0010, 8'h22, 1, 1);
        vecs[6]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b0100, 8'hA5, 2, 1);
        vecs[7]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b1000, 8'h44, 3, 1);
        vecs[8]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b0001, 8'h11, 0, 1);
        vecs[9]  = mkv(1, 0, 4'hF, DATA0, 1, 4'b0010, 8'h22, 1, 1);
        vecs[10] = mkv(1, 0, 4'hF, DATA0, 1, 4'b0100, 8'hA5, 2, 1);
        vecs[11] = mkv(1, 0, 4'hF, DATA0, 1, 4'b1000, 8'h44, 3, 1);
        vecs[12] = mkv(1, 0, 4'h1, DATA0, 1, 4'b0001, 8'h11, 0, 1); // ptr -> 1
        vecs[13] = mkv(1, 0, 4'h9, DATA0, 1, 4'b1000, 8'h44, 3, 1); // skip to ch3, ptr -> 0
        vecs[14] = mkv(1, 0, 4'h9, DATA0, 1, 4'b0001, 8'h11, 0, 1); // then ch0, ptr -> 1
        vecs[15] = mkv(1, 0, 4'h0, DATA0, 1, 4'b0000, 8'h11, 0, 0); // idle drain
        vecs[16] = mkv(1, 0, 4'h4, DATA1, 1, 4'b0100, 8'h3C, 2, 1); // load 3C, ptr -> 3
        vecs[17] = mkv(1, 0, 4'hF, DATA0, 0, 4'b0000, 8'h3C, 2, 1); // backpressure x3
        vecs[18] = mkv(1, 0, 4'hF, DATA0, 0, 4'b0000, 8'h3C, 2, 1);
        vecs[19] = mkv(1, 0, 4'hF, DATA0, 0, 4'b0000, 8'h3C, 2, 1);
        vecs[20] = mkv(1, 0, 4'hF, DATA0, 1, 4'b1000, 8'h44, 3, 1); // drain+load, ptr -> 0
        vecs[21] = mkv(1, 0, 4'hF, DATA0, 1, 4'b0001, 8'h11, 0, 1); // ptr -> 1
        vecs[22] = mkv(0, 1, 4'hF, DATA0, 0, 4'b0000, 8'h11, 0, 1); // switch while holding
        vecs[23] = mkv(0, 1, 4'hF, DATA0, 1, 4'b0010, 8'h22, 1, 1);
        vecs[24] = mkv(0, 3, 4'hF, DATA0, 1, 4'b1000, 8'h44, 3, 1);
        vecs[25] = mkv(1, 0, 4'hF, DATA0, 1, 4'b0010, 8'h22, 1, 1); // resumes at frozen ptr 1
        vecs[26] = mkv(1, 0, 4'hF, DATA0, 1, 4'b0100, 8'hA5, 2, 1);

        // Reset applied before any clock edge; outputs cleared, can_accept = 1.
        Rst_n = 1'b0; Mode = 1'b0; Sel = 2'd2; In_Data = DATA0; In_Valid = 4'hF; Out_Ready = 1'b0;
        #1;
        check("reset_valid", {31'd0, Out_Valid}, 32'd0);
        check("reset_s", {24'd0, S}, 32'd0);
        check("reset_chan", {30'd0, Out_Chan}, 32'd0);
        check("reset_in_ready", {28'd0, In_Ready}, 32'h4);
        // Edges while in reset must not load anything.
        repeat (2) @(posedge Clk);
        #1;
        check("reset_hold_valid", {31'd0, Out_Valid}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge Clk);
            Mode = vecs[i].mode; Sel = vecs[i].sel; In_Valid = vecs[i].valid;
            In_Data = vecs[i].data; Out_Ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), {28'd0, In_Ready}, {28'd0, vecs[i].exp_ready});
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_s", i), {24'd0, S}, {24'd0, vecs[i].exp_s});
            check($sformatf("v%0d_chan", i), {30'd0, Out_Chan}, {30'd0, vecs[i].exp_chan});
            check($sformatf("v%0d_valid", i), {31'd0, Out_Valid}, {31'd0, vecs[i].exp_valid});
            $display("[TB] v%0d mode=%0d sel=%0d vld=%b rdy=%b -> S=%h chan=%0d ov=%0d",
                     i, Mode, Sel, In_Valid, In_Ready, S, Out_Chan, Out_Valid);
        end

        // Mid-operation async reset: Out_Valid=1 with S=A5; hold it, then assert
        // reset between edges and look immediately.
        Out_Ready = 1'b0; Mode = 1'b1; In_Valid = 4'hF;
        #2;
        check("pre_reset_valid", {31'd0, Out_Valid}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, Out_Valid}, 32'd0);
        check("async_reset_s", {24'd0, S}, 32'd0);
        check("async_reset_chan", {30'd0, Out_Chan}, 32'd0);
        // Pointer was 3; reset returns it to 0, so ch0 is offered.
        check("async_reset_in_ready", {28'd0, In_Ready}, 32'h1);
        @(negedge Clk);
        Rst_n = 1'b1;
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        check("post_reset_chan", {30'd0, Out_Chan}, 32'd0);
        check("post_reset_s", {24'd0, S}, 32'h11);
        check("post_reset_valid", {31'd0, Out_Valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_rr_nxw
